// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared state type, field widths and note periods for the tone synth
package synth_pkg;

  localparam int SYNTH_PERIOD_W = 19;
  localparam int SYNTH_DUR_W    = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_PLAY,
    ST_GAP
  } seq_state_t;

  // Square-wave periods in clk48m cycles (48 MHz divided by the note frequency).
  localparam int unsigned NOTE_C4 = 183468;
  localparam int unsigned NOTE_D4 = 163452;
  localparam int unsigned NOTE_E4 = 145619;
  localparam int unsigned NOTE_F4 = 137446;
  localparam int unsigned NOTE_G4 = 122451;
  localparam int unsigned NOTE_A4 = 109091;
  localparam int unsigned NOTE_B4 = 97189;
  localparam int unsigned NOTE_C5 = 91734;
  localparam int unsigned NOTE_D5 = 81726;
  localparam int unsigned NOTE_E5 = 72810;
  localparam int unsigned NOTE_F5 = 68723;
  localparam int unsigned NOTE_G5 = 61226;
  localparam int unsigned NOTE_A5 = 54545;
  localparam int unsigned NOTE_B5 = 48595;
  localparam int unsigned NOTE_C6 = 45867;
  localparam int unsigned NOTE_REST = 0;

  function automatic logic [SYNTH_PERIOD_W+SYNTH_DUR_W-1:0] pack_note(
    input int unsigned p,
    input int unsigned d
  );
    return {p[SYNTH_PERIOD_W-1:0], d[SYNTH_DUR_W-1:0]};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divider producing a one-cycle tick every DIV clocks
module tick_prescaler #(
  parameter int DIV = 48000
) (
  input  logic clk48m,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk48m or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - steps an external {period, dur} note table and drives period/gate
module note_sequencer
  import synth_pkg::*;
#(
  parameter int CLK_HZ    = 48000000,
  parameter int TICK_HZ   = 1000,
  parameter int ADDR_W    = 5,
  parameter int PERIOD_W  = SYNTH_PERIOD_W,
  parameter int DUR_W     = SYNTH_DUR_W,
  parameter int GAP_TICKS = 10
) (
  input  logic                      clk48m,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop_en,
  output logic [ADDR_W-1:0]         step_addr,
  input  logic [PERIOD_W+DUR_W-1:0] step_data,
  output logic [PERIOD_W-1:0]       period,
  output logic                      gate,
  output logic                      busy,
  output logic                      done
);

  seq_state_t          r_state;
  logic [ADDR_W-1:0]   r_idx;
  logic [DUR_W-1:0]    r_dur;
  logic [PERIOD_W-1:0] r_period;
  logic                r_gate;
  logic                r_busy;
  logic                r_done;

  logic                w_tick;
  logic                w_clear;
  logic                w_last;
  logic                w_advance;
  logic [PERIOD_W-1:0] w_period_f;
  logic [DUR_W-1:0]    w_dur_f;

  assign w_period_f = step_data[PERIOD_W+DUR_W-1:DUR_W];
  assign w_dur_f    = step_data[DUR_W-1:0];

  // Holding the prescaler at zero outside PLAY/GAP aligns every note and gap to its entry edge.
  assign w_clear   = (r_state != ST_PLAY) && (r_state != ST_GAP);
  assign w_last    = (r_dur == DUR_W'(1));
  assign w_advance = w_tick && w_last &&
                     ((r_state == ST_GAP) || ((r_state == ST_PLAY) && (GAP_TICKS == 0)));

  tick_prescaler #(
    .DIV(CLK_HZ / TICK_HZ)
  ) u_prescaler (
    .clk48m(clk48m),
    .rst_n (rst_n),
    .clear (w_clear),
    .tick  (w_tick)
  );

  always_ff @(posedge clk48m or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_dur    <= '0;
      r_period <= '0;
      r_gate   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != ST_IDLE) && stop) begin
        r_state  <= ST_IDLE;
        r_period <= '0;
        r_gate   <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !stop) begin
              r_idx   <= '0;
              r_state <= ST_FETCH;
              r_busy  <= 1'b1;
            end
          end
          ST_FETCH: r_state <= ST_DECODE;
          ST_DECODE: begin
            if (w_dur_f == '0) begin
              if (loop_en && (r_idx != '0)) begin
                r_idx   <= '0;
                r_state <= ST_FETCH;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_period <= w_period_f;
              r_gate   <= (w_period_f != '0);
              r_dur    <= w_dur_f;
              r_state  <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (w_tick) begin
              r_dur <= r_dur - 1'b1;
              if (w_last) begin
                r_period <= '0;
                r_gate   <= 1'b0;
                if (GAP_TICKS > 0) begin
                  r_state <= ST_GAP;
                  r_dur   <= DUR_W'(GAP_TICKS);
                end
              end
            end
          end
          ST_GAP: begin
            if (w_tick) begin
              r_dur <= r_dur - 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase

        // Running off the table end wraps idx to 0, so the loop rule cannot fire there.
        if (w_advance) begin
          if (r_idx == '1) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= ST_FETCH;
          end
        end
      end
    end
  end

  assign step_addr = r_idx;
  assign period    = r_period;
  assign gate      = r_gate;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - note_sequencer against a per-cycle timeline built from the note table
module tb_note_sequencer;
  import synth_pkg::*;

  localparam int CLK_HZ    = 1000;
  localparam int TICK_HZ   = 100;
  localparam int ADDR_W    = 3;
  localparam int GAP_TICKS = 2;
  localparam int PW        = SYNTH_PERIOD_W;
  localparam int DW        = SYNTH_DUR_W;
  localparam int TCYC      = CLK_HZ / TICK_HZ;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clk48m = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic [ADDR_W-1:0] step_addr;
  logic [PW+DW-1:0]  step_data = '0;
  logic [PW-1:0]     period;
  logic              gate;
  logic              busy;
  logic              done;

  note_sequencer #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .ADDR_W   (ADDR_W),
    .PERIOD_W (PW),
    .DUR_W    (DW),
    .GAP_TICKS(GAP_TICKS)
  ) u_dut (
    .clk48m   (clk48m),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .step_addr(step_addr),
    .step_data(step_data),
    .period   (period),
    .gate     (gate),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk48m = ~clk48m;

  int unsigned tbl_p [DEPTH];
  int unsigned tbl_d [DEPTH];

  // Synchronous table ROM: data follows the address by one clock.
  always @(posedge clk48m) step_data <= pack_note(tbl_p[step_addr], tbl_d[step_addr]);

  typedef struct {
    int unsigned p;
    bit          g;
    bit          b;
    bit          d;
    int unsigned a;
  } smp_t;

  smp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic void push(input int unsigned p, input bit g, input bit b, input bit d,
                               input int unsigned a);
    smp_t s;
    s.p = p; s.g = g; s.b = b; s.d = d; s.a = a;
    exp_q.push_back(s);
  endfunction

  // Expected samples, one per clock, starting the cycle after start is taken.
  function automatic void build(input bit lp, input int maxlen);
    int unsigned idx = 0;
    exp_q.delete();
    while (exp_q.size() < maxlen) begin
      push(0, 0, 1, 0, idx);
      push(0, 0, 1, 0, idx);
      if (tbl_d[idx] == 0) begin
        if (lp && idx != 0) begin
          idx = 0;
          continue;
        end
        push(0, 0, 0, 1, 0);
        break;
      end
      repeat (tbl_d[idx] * TCYC) push(tbl_p[idx], tbl_p[idx] != 0, 1, 0, idx);
      repeat (GAP_TICKS * TCYC) push(0, 0, 1, 0, idx);
      if (idx == DEPTH - 1) begin
        push(0, 0, 0, 1, 0);
        break;
      end
      idx++;
    end
    repeat (3) push(0, 0, 0, 0, 0);
    while (exp_q.size() > maxlen) void'(exp_q.pop_back());
  endfunction

  task automatic run_song(input string tag, input bit lp, input int maxlen,
                          input int stop_i, input int start_i);
    build(lp, maxlen);
    if (stop_i >= 0) begin
      for (int i = stop_i + 1; i < exp_q.size(); i++) begin
        exp_q[i].p = 0; exp_q[i].g = 0; exp_q[i].b = 0; exp_q[i].d = 0;
      end
    end
    loop_en = lp;
    @(negedge clk48m);
    start = 1'b1;
    @(posedge clk48m);
    #1 start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk48m);
      chk($sformatf("%s.out[%0d]", tag, i), {10'b0, period, gate, busy, done},
          {10'b0, PW'(exp_q[i].p), exp_q[i].g, exp_q[i].b, exp_q[i].d});
      if (exp_q[i].b) chk($sformatf("%s.addr[%0d]", tag, i), 32'(step_addr), exp_q[i].a);
      stop  = (i == stop_i);
      start = (i == start_i);
    end
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk48m) stop = 1'b1;
    @(negedge clk48m) stop = 1'b0;
    repeat (2) @(negedge clk48m);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tbl_p[i] = 300 + i;
      tbl_d[i] = 1;
    end
    repeat (3) @(negedge clk48m);
    chk("reset.out", {10'b0, period, gate, busy, done}, 32'd0);
    chk("reset.addr", 32'(step_addr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk48m);

    tbl_p[0] = 1000; tbl_d[0] = 3;
    tbl_p[1] = 0;    tbl_d[1] = 2;
    tbl_p[2] = 500;  tbl_d[2] = 1;
    tbl_p[3] = 777;  tbl_d[3] = 0;
    run_song("song", 1'b0, 400, -1, -1);
    run_song("loop", 1'b1, 300, -1, -1);
    run_song("start_busy", 1'b0, 400, -1, 20);
    run_song("stop", 1'b0, 400, 17, -1);
    run_song("replay", 1'b0, 400, -1, -1);

    tbl_d[0] = 0;
    run_song("empty_loop", 1'b1, 40, -1, -1);

    @(negedge clk48m);
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk48m);
    #1 start = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk48m);
      chk($sformatf("start_stop[%0d]", i), {10'b0, period, gate, busy, done}, 32'd0);
    end

    for (int i = 0; i < DEPTH; i++) begin
      tbl_p[i] = 100 * (i + 1);
      tbl_d[i] = 1;
    end
    run_song("full", 1'b0, 500, -1, -1);

    loop_en = 1'b0;
    @(negedge clk48m);
    start = 1'b1;
    @(posedge clk48m);
    #1 start = 1'b0;
    repeat (2 + TCYC + 5) @(negedge clk48m);
    chk("pre_reset.busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset.out", {10'b0, period, gate, busy, done}, 32'd0);
    chk("async_reset.addr", 32'(step_addr), 32'd0);
    @(negedge clk48m) rst_n = 1'b1;
    repeat (40) @(negedge clk48m);
    chk("no_resume.out", {10'b0, period, gate, busy, done}, 32'd0);

    for (int r = 0; r < 12; r++) begin
      int m;
      bit lp;
      m  = $urandom_range(0, DEPTH);
      lp = 1'($urandom_range(0, 1));
      for (int i = 0; i < DEPTH; i++) begin
        tbl_p[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, (1 << PW) - 1);
        tbl_d[i] = $urandom_range(1, 3);
      end
      if (m < DEPTH) tbl_d[m] = 0;
      else lp = 1'b0;
      run_song($sformatf("rand%0d", r), lp, 500, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
